// File: rtl/semaforo_fsm_pkg.sv
// semaforo_fsm_pkg: state codes and default timing for the traffic-light controller
package semaforo_fsm_pkg;
  typedef enum logic [1:0] {
    ST_VERDE    = 2'd0,
    ST_AMARELO  = 2'd1,
    ST_VERMELHO = 2'd2,
    ST_PEDESTRE = 2'd3
  } estado_t;
  localparam int DEF_TEMPO_VERDE     = 8;
  localparam int DEF_TEMPO_VERDE_MIN = 3;
  localparam int DEF_TEMPO_AMARELO   = 3;
  localparam int DEF_TEMPO_VERMELHO  = 2;
  localparam int DEF_TEMPO_PEDESTRE  = 6;
  localparam int DEF_TEMPO_PISCA     = 2;
  localparam int DEF_LARG_CONT       = 4;
endpackage

// File: rtl/semaforo_fsm_sincronizador_borda.sv
// sincronizador_borda: 2-flop synchroniser with one-clk rising-edge pulse
module sincronizador_borda (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic pulso
);
  logic r_s1, r_s2, r_s3;
  // synchroniser chain plus previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_s1, r_s2, r_s3} <= 3'b000;
    else {r_s1, r_s2, r_s3} <= {d_async, r_s1, r_s2};
  assign pulso = r_s2 & ~r_s3;
endmodule

// File: rtl/semaforo_fsm.sv
// semaforo_fsm: traffic-light controller with pedestrian crossing, stepped by tick_lento edges
module semaforo_fsm
  import semaforo_fsm_pkg::*;
#(
  parameter int TEMPO_VERDE     = DEF_TEMPO_VERDE,
  parameter int TEMPO_VERDE_MIN = DEF_TEMPO_VERDE_MIN,
  parameter int TEMPO_AMARELO   = DEF_TEMPO_AMARELO,
  parameter int TEMPO_VERMELHO  = DEF_TEMPO_VERMELHO,
  parameter int TEMPO_PEDESTRE  = DEF_TEMPO_PEDESTRE,
  parameter int TEMPO_PISCA     = DEF_TEMPO_PISCA,
  parameter int LARG_CONT       = DEF_LARG_CONT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_lento,
  input  logic       botao_pedestre,
  output logic       verde,
  output logic       amarelo,
  output logic       vermelho,
  output logic       pedestre_verde,
  output logic       pedestre_vermelho,
  output logic       pedido_pendente,
  output logic [1:0] estado
);
  localparam logic [LARG_CONT-1:0] FIM_VD    = LARG_CONT'(TEMPO_VERDE - 1);
  localparam logic [LARG_CONT-1:0] MIN_VD    = LARG_CONT'(TEMPO_VERDE_MIN - 1);
  localparam logic [LARG_CONT-1:0] FIM_AM    = LARG_CONT'(TEMPO_AMARELO - 1);
  localparam logic [LARG_CONT-1:0] FIM_VM    = LARG_CONT'(TEMPO_VERMELHO - 1);
  localparam logic [LARG_CONT-1:0] FIM_PD    = LARG_CONT'(TEMPO_PEDESTRE - 1);
  localparam logic [LARG_CONT-1:0] INI_PISCA = LARG_CONT'(TEMPO_PEDESTRE - TEMPO_PISCA);
  estado_t              r_estado, w_estado_nx, w_sucessor;
  logic [LARG_CONT-1:0] r_conta, w_conta_nx, w_fim, w_desl;
  logic                 r_pedido, w_pedido_nx, w_tick, w_botao, w_sai;
  sincronizador_borda u_sync_tick  (.clk(clk), .rst(rst), .d_async(tick_lento),     .pulso(w_tick));
  sincronizador_borda u_sync_botao (.clk(clk), .rst(rst), .d_async(botao_pedestre), .pulso(w_botao));
  // state, tick counter and request latch registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_estado <= ST_VERMELHO;
      r_conta  <= '0;
      r_pedido <= 1'b0;
    end else begin
      r_estado <= w_estado_nx;
      r_conta  <= w_conta_nx;
      r_pedido <= w_pedido_nx;
    end
  // next state: advance on tick at end of duration or on early green exit; entering PEDESTRE clears the request
  always_comb begin
    w_estado_nx = r_estado;
    w_conta_nx  = r_conta;
    w_pedido_nx = r_pedido;
    w_fim = r_estado == ST_VERDE   ? FIM_VD :
            r_estado == ST_AMARELO ? FIM_AM :
            r_estado == ST_VERMELHO ? FIM_VM : FIM_PD;
    w_sucessor = r_estado == ST_VERDE    ? ST_AMARELO :
                 r_estado == ST_AMARELO  ? ST_VERMELHO :
                 r_estado == ST_VERMELHO ? (r_pedido ? ST_PEDESTRE : ST_VERDE) : ST_VERDE;
    w_sai = r_conta == w_fim || (r_estado == ST_VERDE && r_pedido && r_conta >= MIN_VD);
    if (w_tick) begin
      w_estado_nx = w_sai ? w_sucessor : r_estado;
      w_conta_nx  = w_sai ? '0 : r_conta + 1'b1;
    end
    if (w_tick && w_sai && w_sucessor == ST_PEDESTRE) w_pedido_nx = 1'b0;
    else if (w_botao && r_estado != ST_PEDESTRE) w_pedido_nx = 1'b1;
  end
  assign w_desl            = r_conta - INI_PISCA;
  assign verde             = r_estado == ST_VERDE;
  assign amarelo           = r_estado == ST_AMARELO;
  assign vermelho          = r_estado == ST_VERMELHO || r_estado == ST_PEDESTRE;
  assign pedestre_vermelho = r_estado != ST_PEDESTRE;
  assign pedestre_verde    = r_estado == ST_PEDESTRE && (r_conta < INI_PISCA || w_desl[0]);
  assign pedido_pendente   = r_pedido;
  assign estado            = r_estado;
endmodule

// File: tb/tb_semaforo_fsm.sv
// tb_semaforo_fsm: directed checks of the traffic-light controller
module tb_semaforo_fsm;
  localparam logic [4:0] L_VD   = 5'b10001;
  localparam logic [4:0] L_AM   = 5'b01001;
  localparam logic [4:0] L_VM   = 5'b00101;
  localparam logic [4:0] L_PON  = 5'b00110;
  localparam logic [4:0] L_POFF = 5'b00100;
  logic clk, rst, tick_lento, botao_pedestre;
  logic verde, amarelo, vermelho, pedestre_verde, pedestre_vermelho, pedido_pendente;
  logic [1:0] estado;
  logic [7:0] obs;
  int n_tests = 0, n_fail = 0;
  semaforo_fsm dut (
    .clk(clk), .rst(rst), .tick_lento(tick_lento), .botao_pedestre(botao_pedestre),
    .verde(verde), .amarelo(amarelo), .vermelho(vermelho), .pedestre_verde(pedestre_verde),
    .pedestre_vermelho(pedestre_vermelho), .pedido_pendente(pedido_pendente), .estado(estado)
  );
  assign obs = {verde, amarelo, vermelho, pedestre_verde, pedestre_vermelho, pedido_pendente, estado};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    tick_lento = 1'b1;
    repeat (8) @(negedge clk);
    tick_lento = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic press();
    botao_pedestre = 1'b1;
    repeat (4) @(negedge clk);
    botao_pedestre = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b0; tick_lento = 1'b0; botao_pedestre = 1'b0;
    #1 rst = 1'b1;
    #1 n_tests++;
    if (obs !== {L_VM, 1'b0, 2'd2}) begin n_fail++; $display("FAIL reset_async obs=%b want=%b", obs, {L_VM, 1'b0, 2'd2}); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== {L_VM, 1'b0, 2'd2}) begin n_fail++; $display("FAIL reset_hold obs=%b want=%b", obs, {L_VM, 1'b0, 2'd2}); end
    rst = 1'b0;
  endtask
  task automatic test_cycle();
    logic [7:0] e;
    for (int i = 1; i <= 14; i++) begin
      tick();
      e = i == 1 ? {L_VM, 1'b0, 2'd2} : i <= 9 ? {L_VD, 1'b0, 2'd0} :
          i <= 12 ? {L_AM, 1'b0, 2'd1} : {L_VM, 1'b0, 2'd2};
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL cycle tick%0d obs=%b want=%b", i, obs, e); end
    end
  endtask
  task automatic test_latency();
    tick_lento = 1'b1;
    @(negedge clk);
    n_tests++;
    if (estado !== 2'd2) begin n_fail++; $display("FAIL lat_k estado=%0d want=2", estado); end
    @(negedge clk);
    tick_lento = 1'b0;
    n_tests++;
    if (estado !== 2'd2) begin n_fail++; $display("FAIL lat_k1 estado=%0d want=2", estado); end
    @(negedge clk);
    n_tests++;
    if (estado !== 2'd0) begin n_fail++; $display("FAIL lat_k2 estado=%0d want=0", estado); end
    repeat (8) @(negedge clk);
    tick_lento = 1'b1;
    repeat (100) @(negedge clk);
    tick_lento = 1'b0;
    repeat (8) @(negedge clk);
    repeat (6) tick();
    n_tests++;
    if (obs !== {L_VD, 1'b0, 2'd0}) begin n_fail++; $display("FAIL long_level obs=%b want=%b", obs, {L_VD, 1'b0, 2'd0}); end
    tick();
    n_tests++;
    if (obs !== {L_AM, 1'b0, 2'd1}) begin n_fail++; $display("FAIL green_end obs=%b want=%b", obs, {L_AM, 1'b0, 2'd1}); end
  endtask
  task automatic test_reset_mid();
    tick();
    press();
    n_tests++;
    if (obs !== {L_AM, 1'b1, 2'd1}) begin n_fail++; $display("FAIL pre_reset obs=%b want=%b", obs, {L_AM, 1'b1, 2'd1}); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 n_tests++;
    if (obs !== {L_VM, 1'b0, 2'd2}) begin n_fail++; $display("FAIL reset_mid obs=%b want=%b", obs, {L_VM, 1'b0, 2'd2}); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_pedestrian();
    logic [7:0] e;
    repeat (2) tick();
    press();
    n_tests++;
    if (obs !== {L_VD, 1'b1, 2'd0}) begin n_fail++; $display("FAIL press_latch obs=%b want=%b", obs, {L_VD, 1'b1, 2'd0}); end
    for (int i = 1; i <= 14; i++) begin
      tick();
      e = i <= 2 ? {L_VD, 1'b1, 2'd0} : i <= 5 ? {L_AM, 1'b1, 2'd1} : i <= 7 ? {L_VM, 1'b1, 2'd2} :
          i == 12 ? {L_POFF, 1'b0, 2'd3} : i <= 13 ? {L_PON, 1'b0, 2'd3} : {L_VD, 1'b0, 2'd0};
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL ped tick%0d obs=%b want=%b", i, obs, e); end
    end
  endtask
  task automatic test_back_to_back();
    repeat (8) tick();
    repeat (3) press();
    repeat (5) tick();
    n_tests++;
    if (obs !== {L_PON, 1'b0, 2'd3}) begin n_fail++; $display("FAIL multi_press obs=%b want=%b", obs, {L_PON, 1'b0, 2'd3}); end
    press();
    n_tests++;
    if (pedido_pendente !== 1'b0) begin n_fail++; $display("FAIL press_in_ped pedido=%b want=0", pedido_pendente); end
    repeat (13) tick();
    n_tests++;
    if (obs !== {L_VD, 1'b0, 2'd0}) begin n_fail++; $display("FAIL full_green obs=%b want=%b", obs, {L_VD, 1'b0, 2'd0}); end
    tick();
    n_tests++;
    if (obs !== {L_AM, 1'b0, 2'd1}) begin n_fail++; $display("FAIL full_green_end obs=%b want=%b", obs, {L_AM, 1'b0, 2'd1}); end
    repeat (5) tick();
    n_tests++;
    if (obs !== {L_VD, 1'b0, 2'd0}) begin n_fail++; $display("FAIL one_crossing obs=%b want=%b", obs, {L_VD, 1'b0, 2'd0}); end
  endtask
  task automatic test_entry_collision();
    repeat (8) tick();
    press();
    repeat (4) tick();
    n_tests++;
    if (obs !== {L_VM, 1'b1, 2'd2}) begin n_fail++; $display("FAIL pre_entry obs=%b want=%b", obs, {L_VM, 1'b1, 2'd2}); end
    tick_lento = 1'b1; botao_pedestre = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (obs !== {L_PON, 1'b0, 2'd3}) begin n_fail++; $display("FAIL entry_clear obs=%b want=%b", obs, {L_PON, 1'b0, 2'd3}); end
    repeat (5) @(negedge clk);
    tick_lento = 1'b0; botao_pedestre = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (pedido_pendente !== 1'b0) begin n_fail++; $display("FAIL entry_after pedido=%b want=0", pedido_pendente); end
  endtask
  initial begin
    test_reset();
    test_cycle();
    test_latency();
    test_reset_mid();
    test_pedestrian();
    test_back_to_back();
    test_entry_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
